// File: rtl/signed_channel_tx_pkg.sv
// Shared definitions for the signed multi-channel link: FSM states and channel-index width.
package signed_channel_tx_pkg;

  typedef enum logic {
    StIdle,
    StSend
  } tx_state_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int unsigned chan_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/signed_channel_tx_prio_enc.sv
// Lowest-set-bit priority encoder; also flags when exactly one bit is set.
module signed_channel_tx_prio_enc
  import signed_channel_tx_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned CW = chan_width(N)
) (
  input  logic [N-1:0]  mask,
  output logic [CW-1:0] idx,
  output logic          valid,
  output logic          only_one
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = CW'(i);
    end
    valid    = |mask;
    only_one = valid && ((mask & (mask - 1'b1)) == '0);
  end

endmodule

// File: rtl/signed_channel_tx.sv
// Zero-suppressing transmitter: captures a frame of signed samples and streams the channels
// above threshold, in ascending order, over a valid/ready link.
module signed_channel_tx
  import signed_channel_tx_pkg::*;
#(
  parameter int unsigned BITS = 8,
  parameter int unsigned CHANNELS = 2,
  localparam int unsigned W = BITS + 1,
  localparam int unsigned CW = chan_width(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  input  logic [CHANNELS*W-1:0] chn_values,
  input  logic [W-1:0]          threshold,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [W-1:0]          tx_data,
  output logic [CW-1:0]         tx_chan,
  output logic                  tx_last,
  output logic [15:0]           hit_count
);

  tx_state_e             state_q;
  logic                  frame_ready_q;
  logic                  tx_valid_q;
  logic [W-1:0]          tx_data_q;
  logic [CW-1:0]         tx_chan_q;
  logic                  tx_last_q;
  logic [15:0]           hit_count_q, hit_count_d;
  logic [CHANNELS*W-1:0] samples_q;
  // Hits still waiting to be presented; the word on tx_* is already removed.
  logic [CHANNELS-1:0]   mask_q;

  logic [CHANNELS-1:0]   hit_now;
  logic [CHANNELS-1:0]   enc_in;
  logic [CHANNELS-1:0]   mask_rest;
  logic [CHANNELS*W-1:0] frame_src;
  logic [W-1:0]          sel_data;
  logic [CW-1:0]         enc_idx;
  logic                  enc_valid;
  logic                  enc_only_one;
  logic                  capture;
  logic                  handshake;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_cmp
    assign hit_now[c] = $signed(chn_values[c*W +: W]) > $signed(threshold);
  end

  // In IDLE the encoder looks at the incoming frame so the first hit is presented right after
  // capture; in SEND it walks the stored remainder.
  assign capture   = (state_q == StIdle) && frame_valid && frame_ready_q;
  assign handshake = tx_valid_q && tx_ready;
  assign enc_in    = (state_q == StIdle) ? hit_now : mask_q;
  assign frame_src = (state_q == StIdle) ? chn_values : samples_q;
  assign mask_rest = enc_in & (enc_in - 1'b1);

  signed_channel_tx_prio_enc #(
    .N(CHANNELS)
  ) u_prio_enc (
    .mask    (enc_in),
    .idx     (enc_idx),
    .valid   (enc_valid),
    .only_one(enc_only_one)
  );

  always_comb begin
    sel_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (enc_idx == CW'(c)) sel_data = frame_src[c*W +: W];
    end
  end

  always_comb begin
    hit_count_d = hit_count_q;
    if (handshake && (hit_count_q != 16'hFFFF)) hit_count_d = hit_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hit_count_q <= '0;
    else       hit_count_q <= hit_count_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      frame_ready_q <= 1'b1;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      tx_chan_q     <= '0;
      tx_last_q     <= 1'b0;
      samples_q     <= '0;
      mask_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (capture) begin
            samples_q <= chn_values;
            if (enc_valid) begin
              state_q       <= StSend;
              frame_ready_q <= 1'b0;
              tx_valid_q    <= 1'b1;
              tx_data_q     <= sel_data;
              tx_chan_q     <= enc_idx;
              tx_last_q     <= enc_only_one;
              mask_q        <= mask_rest;
            end
          end
        end
        StSend: begin
          if (handshake) begin
            if (tx_last_q) begin
              state_q       <= StIdle;
              frame_ready_q <= 1'b1;
              tx_valid_q    <= 1'b0;
              tx_last_q     <= 1'b0;
              mask_q        <= '0;
            end else begin
              tx_data_q <= sel_data;
              tx_chan_q <= enc_idx;
              tx_last_q <= enc_only_one;
              mask_q    <= mask_rest;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign frame_ready = frame_ready_q;
  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign tx_chan     = tx_chan_q;
  assign tx_last     = tx_last_q;
  assign hit_count   = hit_count_q;

endmodule
